// File: rtl/gf3m_pkg.sv
// Shared definitions for GF(3^97) arithmetic modulo P(x) = x^97 + x^12 + 2.
package gf3m_pkg;

  localparam int unsigned GF3M_M = 97;
  localparam int unsigned ELEM_W = 2 * GF3M_M;

  // Coefficient encodings; 2'b11 is not a legal code.
  localparam logic [1:0] F3_ZERO = 2'b00;
  localparam logic [1:0] F3_ONE  = 2'b01;
  localparam logic [1:0] F3_TWO  = 2'b10;

  // Reduction taps: coefficient 12 and coefficient 0 feed targets 11 and 96.
  localparam int unsigned TAP_HI = 12;
  localparam int unsigned TAP_LO = 0;
  localparam int unsigned TGT_HI = 11;
  localparam int unsigned TGT_LO = GF3M_M - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // f3 adder cell: per-coefficient addition mod 3, no carries.
  function automatic logic [1:0] f3_add(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] s;
    unique case (a)
      F3_ZERO: s = b;
      F3_ONE:  s = (b == F3_ZERO) ? F3_ONE : ((b == F3_ONE) ? F3_TWO : F3_ZERO);
      default: s = (b == F3_ZERO) ? F3_TWO : ((b == F3_ONE) ? F3_ZERO : F3_ONE);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gf3m_div_x.sv
// Combinational exact division by x: y = (a + a0*P) / x.
module gf3m_div_x
  import gf3m_pkg::*;
#(
  parameter int unsigned M = GF3M_M
) (
  input  logic [2*M-1:0] a,
  output logic [2*M-1:0] y
);

  logic [1:0] a0;

  assign a0 = a[2*TAP_LO +: 2];

  // Shift coefficients down one place and fold a0*P back in at the tap targets.
  always_comb begin
    y = '0;
    for (int i = 0; i < int'(M) - 1; i++) begin
      y[2*i +: 2] = a[2*(i+1) +: 2];
    end
    y[2*TGT_HI +: 2] = f3_add(a[2*TAP_HI +: 2], a0);
    y[2*TGT_LO +: 2] = a0;
  end

endmodule

// File: rtl/gf3m_div_x_seq.sv
// Sequential C = A * x^-k mod P(x), one division by x per RUN cycle.
// Optional macro GF3M_DIVX_DOUBLE_STEP_EN: two chained divisions per RUN cycle.
module gf3m_div_x_seq
  import gf3m_pkg::*;
#(
  parameter int unsigned M   = GF3M_M,
  parameter int unsigned K_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2*M-1:0]   a_in,
  input  logic [K_W-1:0]   k,
  output logic             busy,
  output logic             done,
  output logic [2*M-1:0]   c_out
);

  localparam int unsigned W = 2 * M;

  state_t          state;
  logic [W-1:0]    work;
  logic [K_W-1:0]  cnt;
  logic [W-1:0]    step1;
  logic [W-1:0]    nxt_c;
  logic [K_W-1:0]  cnt_nxt_c;
  logic            last_c;

  gf3m_div_x #(.M(M)) u_step1 (.a(work), .y(step1));

`ifdef GF3M_DIVX_DOUBLE_STEP_EN
  logic [W-1:0] step2;

  gf3m_div_x #(.M(M)) u_step2 (.a(step1), .y(step2));

  // Two steps per cycle; a lone remaining step uses only the first stage.
  always_comb begin
    nxt_c     = step2;
    cnt_nxt_c = cnt - K_W'(2);
    last_c    = (cnt <= K_W'(2));
    if (cnt == K_W'(1)) begin
      nxt_c     = step1;
      cnt_nxt_c = '0;
    end
  end
`else
  // One step per cycle.
  always_comb begin
    nxt_c     = step1;
    cnt_nxt_c = cnt - K_W'(1);
    last_c    = (cnt == K_W'(1));
  end
`endif

  // Control FSM with registered busy/done/c_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      work  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      c_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            work <= a_in;
            cnt  <= k;
            if (k == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              c_out <= a_in;
              busy  <= 1'b0;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          work <= nxt_c;
          cnt  <= cnt_nxt_c;
          if (last_c) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            c_out <= nxt_c;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf3m_div_x_seq.sv
// Directed bench for gf3m_div_x_seq (either step mode).
module tb_gf3m_div_x_seq;

  localparam int unsigned W = 194;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [6:0]   k = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] c_out;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] one_v;
  logic [W-1:0] res;
  logic [W-1:0] ra;
  logic [W-1:0] acc;
  int           lat;
  int           bcnt;
  int           kk;

  always #5 clk = ~clk;

  gf3m_div_x_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a_in    (a_in),
    .k       (k),
    .busy    (busy),
    .done    (done),
    .c_out   (c_out)
  );

  function automatic logic [1:0] add3(input logic [1:0] x, input logic [1:0] y);
    int s;
    s = (int'(x) + int'(y)) % 3;
    return 2'(s);
  endfunction

  // Multiply by x: x^97 = -x^12 - 2 = 2x^12 + 1 (mod 3, mod P).
  function automatic logic [W-1:0] mulx(input logic [W-1:0] a);
    logic [W-1:0] r;
    logic [1:0]   top;
    top = a[193:192];
    r = a << 2;
    r[1:0] = top;
    r[25:24] = add3(a[23:22], add3(top, top));
    return r;
  endfunction

  function automatic logic [W-1:0] rand_elem();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 97; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic int exp_lat(input int kv);
`ifdef GF3M_DIVX_DOUBLE_STEP_EN
    return (kv + 1) / 2 + 1;
`else
    return kv + 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Runs one job; optionally pokes start with other operands while busy.
  task automatic run_job(input logic [W-1:0] a, input int kv, input bit poke,
                         output logic [W-1:0] r, output int l, output int b);
    @(negedge clk);
    a_in = a;
    k = 7'(kv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = '0;
    k = 7'd3;
    l = 1;
    b = 0;
    while (!done && l < 400) begin
      if (busy) b++;
      if (poke && l == 3) begin
        start = 1'b1;
        a_in = {97{2'b01}};
        k = 7'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      l++;
    end
    start = 1'b0;
    r = c_out;
    chk("done_seen", W'(done), W'(1));
    chk("busy_low_at_done", W'(busy), W'(0));
    @(posedge clk);
    #1;
    chk("done_one_cycle", W'(done), W'(0));
    chk("c_out_held", c_out, r);
  endtask

  initial begin
    one_v = W'(1);

    // Reset state
    #12;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_c_out", c_out, W'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Inverse element: x^-1 = x^96 + x^11
    run_job(one_v, 1, 1'b0, res, lat, bcnt);
    chk("inv_val", res, (one_v << 192) | (one_v << 22));
    chk("inv_lat", W'(lat), W'(exp_lat(1)));
    chk("inv_busy", W'(bcnt), W'(exp_lat(1) - 1));

    // Clean shift of x
    run_job(W'(4), 1, 1'b0, res, lat, bcnt);
    chk("shift_val", res, one_v);

    // Coefficient 2
    run_job(W'(2), 1, 1'b0, res, lat, bcnt);
    chk("coef2_val", res, (W'(2) << 192) | (W'(2) << 22));

    // x^50 * x^-50 = 1, with start poked mid-run
    run_job(one_v << 100, 50, 1'b1, res, lat, bcnt);
    chk("x50_val", res, one_v);
    chk("x50_lat", W'(lat), W'(exp_lat(50)));
    chk("x50_busy", W'(bcnt), W'(exp_lat(50) - 1));

    // k = 0 passes operand straight through
    ra = rand_elem();
    run_job(ra, 0, 1'b0, res, lat, bcnt);
    chk("k0_val", res, ra);
    chk("k0_lat", W'(lat), W'(1));
    chk("k0_busy", W'(bcnt), W'(0));

    // Round trip through multiply-by-x model
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: kk = 127;
        1: kk = 37;
        2: kk = 96;
        default: kk = 2;
      endcase
      ra = rand_elem();
      run_job(ra, kk, 1'b0, res, lat, bcnt);
      acc = res;
      for (int j = 0; j < kk; j++) acc = mulx(acc);
      chk($sformatf("rt_val_k%0d", kk), acc, ra);
      chk($sformatf("rt_lat_k%0d", kk), W'(lat), W'(exp_lat(kk)));
    end

    // Reset mid-RUN aborts with no done
    @(negedge clk);
    a_in = one_v << 100;
    k = 7'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_rst_busy", W'(busy), W'(1));
    reset_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_c_out", c_out, W'(0));
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", W'(done), W'(0));
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Fresh job after reset
    run_job(one_v << 100, 50, 1'b0, res, lat, bcnt);
    chk("post_rst_val", res, one_v);
    chk("post_rst_lat", W'(lat), W'(exp_lat(50)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
